// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write-only byte FIFO.
// Frames go out LSB first and back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 8,
    parameter int AW           = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        busy,
    output logic        tx,
    output logic [31:0] tx_count
);

    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   btmr, btmr_n;
    logic [2:0]      bidx, bidx_n;
    logic [7:0]      shreg, shreg_n;
    logic            tx_n;
    logic [31:0]     frame_cnt;
    logic            cnt_inc;

    logic [7:0]      mem [DEPTH];
    logic [AW:0]     wptr, rptr, wptr_n, rptr_n;
    logic            push, pop, bit_end;
    logic [7:0]      head;

    // full is the registered value, so a push in the same cycle as a pop is still refused
    assign push   = wr_en && !full;
    assign wptr_n = wptr + (AW+1)'(push);
    assign rptr_n = rptr + (AW+1)'(pop);
    assign head   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
            empty <= (wptr_n == rptr_n);
            if (wr_en && full)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            btmr      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            frame_cnt <= '0;
        end else begin
            state <= state_n;
            btmr  <= btmr_n;
            bidx  <= bidx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
            if (cnt_inc)
                frame_cnt <= frame_cnt + 32'd1;
        end
    end

    assign bit_end = (btmr == LAST);

    always_comb begin
        state_n = state;
        btmr_n  = btmr;
        bidx_n  = bidx;
        shreg_n = shreg;
        pop     = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    btmr_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) begin
                    btmr_n  = '0;
                    bidx_n  = '0;
                    state_n = DATA;
                end else begin
                    btmr_n = btmr + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    btmr_n = '0;
                    if (bidx == 3'd7)
                        state_n = STOP;
                    else
                        bidx_n = bidx + 1'b1;
                end else begin
                    btmr_n = btmr + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    btmr_n  = '0;
                    cnt_inc = 1'b1;
                    // chain straight into the next start bit when more data is queued
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = head;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    btmr_n = btmr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // line level follows the state being entered so tx and state change together
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[bidx_n];
            default: tx_n = 1'b1;
        endcase
    end

    assign busy     = (state != IDLE);
    assign tx_count = frame_cnt;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, DEPTH=8.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        full, empty, overflow, busy, tx;
    logic [31:0] tx_count;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(8), .AW(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .overflow(overflow), .busy(busy),
        .tx(tx), .tx_count(tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level for cycle i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int k;
        k = i / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    // Called at the falling edge of frame cycle 0; checks ncyc cycles and returns
    // at the falling edge following the last checked cycle.
    task automatic check_frame(input logic [7:0] b, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            chk($sformatf("tx[%02h].%0d", b, i), tx, frame_bit(b, i));
            chk($sformatf("busy[%02h].%0d", b, i), busy, 1'b1);
            @(negedge clk);
        end
    endtask

    task automatic push_burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            wr_data = first + 8'(i);
            wr_en   = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_cnt", tx_count, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: idle after reset
        do_reset();
        for (int i = 0; i < 50; i++) begin
            chk("idle_tx", tx, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_empty", empty, 1'b1);
            chk("idle_cnt", tx_count, 32'd0);
            @(negedge clk);
        end

        // 2: single byte 0xA5, check latency and whole frame
        do_reset();
        wr_data = 8'hA5;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        chk("a5_empty_n", empty, 1'b0);
        chk("a5_tx_n", tx, 1'b1);
        chk("a5_busy_n", busy, 1'b0);
        @(negedge clk);
        check_frame(8'hA5, 10*CPB);
        chk("a5_busy_end", busy, 1'b0);
        chk("a5_tx_end", tx, 1'b1);
        chk("a5_cnt", tx_count, 32'd1);
        chk("a5_empty_end", empty, 1'b1);

        // 3: three bytes back-to-back
        do_reset();
        fork
            push_burst(8'h01, 3);
            begin
                @(negedge clk);
                @(negedge clk);
                check_frame(8'h01, 10*CPB);
                check_frame(8'h02, 10*CPB);
                check_frame(8'h03, 10*CPB);
            end
        join
        chk("b2b_busy", busy, 1'b0);
        chk("b2b_cnt", tx_count, 32'd3);
        chk("b2b_empty", empty, 1'b1);

        // 4: ten pushes into an 8-deep FIFO; the last is dropped
        do_reset();
        fork
            push_burst(8'h00, 10);
            begin
                @(negedge clk);
                @(negedge clk);
                for (int f = 0; f < 9; f++)
                    check_frame(8'(f), 10*CPB);
            end
            begin
                repeat (9) @(negedge clk);
                chk("ovf_full", full, 1'b1);
                chk("ovf_pre", overflow, 1'b0);
                @(negedge clk);
                chk("ovf_set", overflow, 1'b1);
                chk("ovf_full2", full, 1'b1);
            end
        join
        chk("ovf_busy", busy, 1'b0);
        chk("ovf_cnt", tx_count, 32'd9);
        chk("ovf_empty", empty, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);

        // 5: reset in the middle of a frame with bytes queued
        do_reset();
        chk("rst_clears_ovf", overflow, 1'b0);
        fork
            push_burst(8'hFF, 3);
            begin
                @(negedge clk);
                @(negedge clk);
                check_frame(8'hFF, 15);
            end
        join
        chk("mid_empty_pre", empty, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_tx", tx, 1'b1);
        chk("mid_empty", empty, 1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_full", full, 1'b0);
        for (int i = 0; i < 60; i++) begin
            chk("mid_quiet_tx", tx, 1'b1);
            @(negedge clk);
        end
        chk("mid_busy_end", busy, 1'b0);
        chk("mid_cnt", tx_count, 32'd0);

        // 6: frame counter wrap
        do_reset();
        force dut.frame_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        chk("wrap_pre", tx_count, 32'hFFFF_FFFF);
        wr_data = 8'h3C;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check_frame(8'h3C, 10*CPB);
        chk("wrap_cnt", tx_count, 32'h0000_0000);
        chk("wrap_busy", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
